// File: rtl/vec_sum_sq.sv
// Sequential x^2 + y^2 + z^2 of three signed 8-bit components, one component at a time.
// Define VEC_SUM_SQ_COMBMUL_EN to square in one cycle instead of the 8-cycle shift-add.
//
// state | meaning
// IDLE  | waiting for start; operands captured on start
// ABS   | magnitude of the current component loaded into the multiplier
// MUL   | squaring the magnitude
// ACC   | square added to the accumulator; next component or finish
// DONE  | sum_out valid, done pulse
module vec_sum_sq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  x_in,
    input  logic [7:0]  y_in,
    input  logic [7:0]  z_in,
    output logic [15:0] sum_out,
    output logic        done,
    output logic        busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ABS  = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_ACC  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]  state;
    logic [1:0]  idx;
    logic [7:0]  x_r, y_r, z_r;
    logic [7:0]  mplier;
    logic [15:0] prod;
    logic [15:0] acc;
    logic [7:0]  comp;
    logic [7:0]  mag;
`ifndef VEC_SUM_SQ_COMBMUL_EN
    logic [15:0] mcand;
    logic [2:0]  bit_cnt;
`endif

    // -128 negates back to 8'h80, which reads correctly as unsigned 128
    always_comb begin
        case (idx)
            2'd1:    comp = y_r;
            2'd2:    comp = z_r;
            default: comp = x_r;
        endcase
        mag = comp[7] ? (~comp + 8'd1) : comp;
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= 2'd0;
            x_r     <= 8'd0;
            y_r     <= 8'd0;
            z_r     <= 8'd0;
            mplier  <= 8'd0;
            prod    <= 16'd0;
            acc     <= 16'd0;
            sum_out <= 16'd0;
`ifndef VEC_SUM_SQ_COMBMUL_EN
            mcand   <= 16'd0;
            bit_cnt <= 3'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_r   <= x_in;
                        y_r   <= y_in;
                        z_r   <= z_in;
                        idx   <= 2'd0;
                        acc   <= 16'd0;
                        state <= S_ABS;
                    end
                end
                S_ABS: begin
                    mplier  <= mag;
                    prod    <= 16'd0;
`ifndef VEC_SUM_SQ_COMBMUL_EN
                    mcand   <= {8'd0, mag};
                    bit_cnt <= 3'd7;
`endif
                    state   <= S_MUL;
                end
                S_MUL: begin
`ifdef VEC_SUM_SQ_COMBMUL_EN
                    prod  <= {8'd0, mplier} * {8'd0, mplier};
                    state <= S_ACC;
`else
                    if (mplier[0])
                        prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (bit_cnt == 3'd0)
                        state <= S_ACC;
                    else
                        bit_cnt <= bit_cnt - 3'd1;
`endif
                end
                S_ACC: begin
                    acc <= acc + prod;
                    if (idx == 2'd2) begin
                        sum_out <= acc + prod;
                        state   <= S_DONE;
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= S_ABS;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
